// File: rtl/deser_rx_if.sv
// Word output bus of the serial receiver.
// The master side (the receiver) presents q/q_valid/perr.
// The slave side (the consumer) answers with q_ready.
interface deser_rx_if #(
   parameter int size = 32
);
   logic [size-1:0] q;
   logic            q_valid;
   logic            q_ready;
   logic            perr;

   modport master (
      output q,
      output q_valid,
      output perr,
      input  q_ready
   );

   modport slave (
      input  q,
      input  q_valid,
      input  perr,
      output q_ready
   );
endinterface

// File: rtl/deser_rx.sv
// deser_rx: MSB-first serial-to-parallel word receiver.
// Bits qualified by sv are collected into a shift register. A frame starts with
// sof+sv and ends after `size` bits. A completed word lands in a one-entry output
// buffer that has a valid/ready handshake. A word that completes while the buffer
// is full and not being drained is dropped, and the sticky ovf flag is raised.
// Optional macro PARITY_EN appends one even-parity bit to each frame and
// reports the result on perr.
module deser_rx #(
   parameter int size = 32
) (
   input  logic            clk,
   input  logic            r,
   input  logic            si,
   input  logic            sv,
   input  logic            sof,
   output logic            busy,
   output logic            ovf,
   deser_rx_if.master      out_bus
);

   localparam int             CW   = $clog2(size + 1);
   localparam logic [CW-1:0]  LAST = CW'(size - 1);

`ifdef PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t            state;
   logic [CW-1:0]     count;
   logic [size-1:0]   shreg;
   logic [size-1:0]   q_reg;
   logic              q_valid_reg;
   logic [size-1:0]   word_next;
   logic [size-1:0]   done_word;
   logic              done;
   logic              accept;
`ifdef PARITY_EN
   logic              perr_reg;
   logic              done_perr;
`endif

   // Work out whether a word completes on this edge, and what that word is.
   always_comb begin
      word_next = {shreg[size-2:0], si};
      done_word = word_next;
      done      = 1'b0;
`ifdef PARITY_EN
      done_perr = 1'b0;
`endif
      accept    = !q_valid_reg || out_bus.q_ready;
      if (sv && !sof) begin
         case (state)
`ifdef PARITY_EN
            PAR: begin
               done      = 1'b1;
               done_word = shreg;
               done_perr = ^{shreg, si};
            end
`else
            SHIFT: begin
               if (count == LAST) begin
                  done = 1'b1;
               end
            end
`endif
            default: begin
               done = 1'b0;
            end
         endcase
      end
   end

   // Receive FSM, shift register, output buffer and overflow flag.
   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         state       <= IDLE;
         count       <= '0;
         shreg       <= '0;
         q_reg       <= '0;
         q_valid_reg <= 1'b0;
         busy        <= 1'b0;
         ovf         <= 1'b0;
`ifdef PARITY_EN
         perr_reg    <= 1'b0;
`endif
      end else begin
         if (q_valid_reg && out_bus.q_ready) begin
            q_valid_reg <= 1'b0;
         end

         if (done) begin
            if (accept) begin
               q_reg       <= done_word;
               q_valid_reg <= 1'b1;
`ifdef PARITY_EN
               perr_reg    <= done_perr;
`endif
            end else begin
               ovf <= 1'b1;
            end
         end

         if (sv) begin
            if (sof) begin
               shreg <= {{(size-1){1'b0}}, si};
               count <= CW'(1);
               state <= SHIFT;
               busy  <= 1'b1;
            end else begin
               case (state)
                  SHIFT: begin
                     shreg <= word_next;
                     if (count == LAST) begin
                        count <= '0;
`ifdef PARITY_EN
                        state <= PAR;
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                     end else begin
                        count <= count + 1'b1;
                     end
                  end
`ifdef PARITY_EN
                  PAR: begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
`endif
                  default: begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign out_bus.q       = q_reg;
   assign out_bus.q_valid = q_valid_reg;
`ifdef PARITY_EN
   assign out_bus.perr    = perr_reg;
`else
   assign out_bus.perr    = 1'b0;
`endif

endmodule

// File: tb/tb_deser_rx.sv
// Testbench for deser_rx with size=8.
// A frame-level model keeps the received bits in a queue. It decides when a word
// completes and what that word is. It then pushes the expected word onto a
// scoreboard. A separate monitor pops an entry from the scoreboard on every
// output transfer and compares it with the DUT.
module tb_deser_rx;

   localparam int SIZE = 8;
`ifdef PARITY_EN
   localparam int FLEN = SIZE + 1;
`else
   localparam int FLEN = SIZE;
`endif

   typedef struct packed {
      logic [SIZE-1:0] w;
      logic            p;
   } exp_t;

   logic clk = 1'b0;
   logic r   = 1'b0;
   logic si  = 1'b0;
   logic sv  = 1'b0;
   logic sof = 1'b0;
   logic busy;
   logic ovf;

   deser_rx_if #(.size(SIZE)) bus ();

   deser_rx #(.size(SIZE)) dut (
      .clk     (clk),
      .r       (r),
      .si      (si),
      .sv      (sv),
      .sof     (sof),
      .busy    (busy),
      .ovf     (ovf),
      .out_bus (bus.master)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   exp_t            exp_q[$];
   bit              m_bits[$];
   bit              m_valid = 1'b0;
   bit [SIZE-1:0]   m_word  = '0;
   bit              m_perr  = 1'b0;
   bit              m_ovf   = 1'b0;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level reference model; advances one clock edge given the inputs applied.
   function automatic void model_step(bit i_si, bit i_sv, bit i_sof, bit i_rdy);
      bit            done  = 1'b0;
      bit [SIZE-1:0] w     = '0;
      bit            par   = 1'b0;
      bit            was_v = m_valid;
      if (i_sv) begin
         if (i_sof) begin
            m_bits.delete();
            m_bits.push_back(i_si);
         end else if (m_bits.size() > 0) begin
            m_bits.push_back(i_si);
            if (m_bits.size() == FLEN) begin
               done = 1'b1;
               for (int i = 0; i < SIZE; i++) w = {w[SIZE-2:0], m_bits[i]};
               for (int i = 0; i < FLEN; i++) par ^= m_bits[i];
               if (FLEN == SIZE) par = 1'b0;
               m_bits.delete();
            end
         end
      end
      if (was_v && i_rdy) m_valid = 1'b0;
      if (done) begin
         if (!was_v || i_rdy) begin
            m_valid = 1'b1;
            m_word  = w;
            m_perr  = par;
            exp_q.push_back('{w: w, p: par});
         end else begin
            m_ovf = 1'b1;
         end
      end
   endfunction

   task automatic apply_stimulus(input bit i_si, input bit i_sv, input bit i_sof, input bit i_rdy);
      @(negedge clk);
      si          = i_si;
      sv          = i_sv;
      sof         = i_sof;
      bus.q_ready = i_rdy;
      @(posedge clk);
      #1;
      if (r) model_step(i_si, i_sv, i_sof, i_rdy);
   endtask

   function automatic bit rand_rdy(int pct);
      return ($urandom_range(99) < pct);
   endfunction

   task automatic send_frame(input logic [SIZE-1:0] w, input bit par,
                             input int min_gap, input int max_gap, input int rdy_pct);
      for (int i = 0; i < FLEN; i++) begin
         bit b;
         int gap;
         b   = (i < SIZE) ? w[SIZE-1-i] : par;
         gap = (i == 0) ? 0 : $urandom_range(max_gap, min_gap);
         repeat (gap) apply_stimulus(1'($urandom), 1'b0, 1'($urandom), rand_rdy(rdy_pct));
         apply_stimulus(b, 1'b1, (i == 0), rand_rdy(rdy_pct));
      end
   endtask

   task automatic send_partial(input int n, input int rdy_pct);
      for (int i = 0; i < n; i++) apply_stimulus(1'($urandom), 1'b1, (i == 0), rand_rdy(rdy_pct));
   endtask

   // Monitor: compares the DUT with the model mid-cycle and pops the scoreboard on each transfer.
   always @(negedge clk) begin
      #2;
      if (r) begin
         check_output("q_valid", bus.q_valid, m_valid);
         check_output("busy", busy, m_bits.size() > 0);
         check_output("ovf", ovf, m_ovf);
         if (m_valid) begin
            check_output("q_hold", bus.q, m_word);
            check_output("perr_hold", bus.perr, m_perr);
         end
         if (bus.q_valid && bus.q_ready) begin
            if (exp_q.size() == 0) begin
               check_output("scoreboard_underflow", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check_output("sb_q", bus.q, e.w);
               check_output("sb_perr", bus.perr, e.p);
            end
         end
      end
   end

   initial begin
      bus.q_ready = 1'b0;
      #3;
      check_output("rst_q", bus.q, 0);
      check_output("rst_q_valid", bus.q_valid, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_ovf", ovf, 0);
      check_output("rst_perr", bus.perr, 0);
      repeat (2) @(negedge clk);
      r = 1'b1;

      // Basic frame, no gaps, consumer always ready.
      send_frame(8'hA5, 1'b0, 0, 0, 100);
      check_output("t1_q", bus.q, 8'hA5);
      check_output("t1_valid", bus.q_valid, 1);
      repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Strobe gaps with random si.
      send_frame(8'h3C, 1'b0, 1, 3, 100);
      repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Overflow: consumer stalled across two frames.
      send_frame(8'h11, 1'b0, 0, 0, 0);
      send_frame(8'h22, 1'b0, 0, 0, 0);
      check_output("t3_q_held", bus.q, 8'h11);
      check_output("t3_ovf", ovf, 1);
      repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
      check_output("t3_ovf_sticky", ovf, 1);

      // Aborted partial frame followed by a full frame.
      send_partial(4, 100);
      send_frame(8'h5A, 1'b0, 0, 0, 100);
      repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset mid-frame.
      send_partial(4, 100);
      #2;
      r = 1'b0;
      #1;
      check_output("ar_q", bus.q, 0);
      check_output("ar_q_valid", bus.q_valid, 0);
      check_output("ar_busy", busy, 0);
      check_output("ar_ovf", ovf, 0);
      check_output("ar_perr", bus.perr, 0);
      m_bits.delete();
      m_valid = 1'b0;
      m_word  = '0;
      m_perr  = 1'b0;
      m_ovf   = 1'b0;
      exp_q.delete();
      repeat (2) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      r = 1'b1;
      send_frame(8'hFF, 1'b0, 0, 0, 100);
      check_output("t5_q", bus.q, 8'hFF);
      check_output("t5_valid", bus.q_valid, 1);
      repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Parity cases (parity bit ignored without PARITY_EN).
      send_frame(8'h07, 1'b1, 0, 0, 100);
      send_frame(8'h07, 1'b0, 0, 0, 100);
      repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Randomized traffic with aborts, gaps and consumer stalls.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(9) == 0) send_partial($urandom_range(FLEN - 1, 1), 70);
         send_frame(SIZE'($urandom), 1'($urandom), 0, $urandom_range(2), 70);
         if ($urandom_range(3) == 0) apply_stimulus(1'($urandom), 1'b0, 1'($urandom), rand_rdy(70));
      end

      repeat (5) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
      check_output("drain_queue", exp_q.size(), 0);
      check_output("drain_valid", bus.q_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
